// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the shift-add multiplier
package mult_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mult_state_e;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_sign_fix.sv
// rtl/mult_sign_fix.sv - conditional negation and overflow check of the magnitude product
module mult_sign_fix
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic               neg,
    input  logic               signed_mode,
    output logic [2*WIDTH-1:0] res,
    output logic               ovf
);

    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] LIMIT = PW'(1) << (WIDTH - 1);

    assign res = neg ? -acc : acc;

    // acc is a magnitude; a negative result may reach -2^(WIDTH-1), a positive one may not
    always_comb begin
        ovf = 1'b0;
        if (!signed_mode) begin
            ovf = |acc[PW-1:WIDTH];
        end else if (neg) begin
            ovf = acc > LIMIT;
        end else begin
            ovf = acc >= LIMIT;
        end
    end

endmodule

// File: rtl/mult.sv
// rtl/mult.sv - sequential radix-2 shift-add multiplier; MULT_EARLY_TERM_EN enables early completion
module mult
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             activate,
    input  logic             a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] div,
    output logic             mod,
    output logic             endop
);

    localparam int CW = cnt_width(WIDTH);
    localparam int PW = 2 * WIDTH;

    mult_state_e      state, state_nx;
    logic [PW-1:0]    acc, mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             mode_s, neg;

    logic [WIDTH-1:0] b_mag, c_mag;
    logic [PW-1:0]    acc_nx;
    logic [WIDTH-1:0] mplier_nx;
    logic             done;
    logic [PW-1:0]    fix_res;
    logic             fix_ovf;

    // Signed mode works on magnitudes; the most negative value maps onto its unsigned pattern
    assign b_mag     = (a && b[WIDTH-1]) ? -b : b;
    assign c_mag     = (a && c[WIDTH-1]) ? -c : c;
    assign acc_nx    = mplier[0] ? acc + mcand : acc;
    assign mplier_nx = mplier >> 1;

`ifdef MULT_EARLY_TERM_EN
    assign done = (state == BUSY) && ((cnt == CW'(1)) || (mplier_nx == '0));
`else
    assign done = (state == BUSY) && (cnt == CW'(1));
`endif

    mult_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .acc         (acc_nx),
        .neg         (neg),
        .signed_mode (mode_s),
        .res         (fix_res),
        .ovf         (fix_ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (activate) state_nx = BUSY;
            BUSY:    if (done)     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            mode_s <= 1'b0;
            neg    <= 1'b0;
            div    <= '0;
            mod    <= 1'b0;
            endop  <= 1'b0;
        end else begin
            endop <= 1'b0;
            if (state == IDLE) begin
                if (activate) begin
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, b_mag};
                    mplier <= c_mag;
                    cnt    <= CW'(WIDTH);
                    mode_s <= a;
                    neg    <= a & (b[WIDTH-1] ^ c[WIDTH-1]);
                end
            end else begin
                acc    <= acc_nx;
                mcand  <= mcand << 1;
                mplier <= mplier_nx;
                cnt    <= cnt - CW'(1);
                if (done) begin
                    div   <= fix_res[WIDTH-1:0];
                    mod   <= fix_ovf;
                    endop <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult.sv
// tb/tb_mult.sv - self-checking bench for mult against an arithmetic reference model
module tb_mult;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         activate;
    logic         a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] div;
    logic         mod;
    logic         endop;

    int passes = 0;
    int total  = 0;

    mult #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .activate (activate),
        .a        (a),
        .b        (b),
        .c        (c),
        .div      (div),
        .mod      (mod),
        .endop    (endop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void model(input logic aa, input logic [W-1:0] bb, input logic [W-1:0] cc,
                                  output logic [W-1:0] d, output logic m, output int lat);
        longint p;
        logic [W-1:0] cm;
        if (aa) begin
            p = longint'($signed(bb)) * longint'($signed(cc));
            m = (p < -(longint'(1) << (W - 1))) || (p > (longint'(1) << (W - 1)) - 1);
            cm = cc[W-1] ? -cc : cc;
        end else begin
            p = longint'(bb) * longint'(cc);
            m = p > (longint'(1) << W) - 1;
            cm = cc;
        end
        d = p[W-1:0];
`ifdef MULT_EARLY_TERM_EN
        lat = 1;
        while (lat < W && (cm >> lat) != 0) lat++;
`else
        lat = W;
`endif
    endfunction

    // Caller is between edges; returns #1 after the edge on which endop was seen
    task automatic run_op(input logic aa, input logic [W-1:0] bb, input logic [W-1:0] cc,
                          input bit hold, input bit scramble, input string tag);
        logic [W-1:0] ed;
        logic em;
        int el;
        int k;
        model(aa, bb, cc, ed, em, el);
        a = aa; b = bb; c = cc; activate = 1'b1;
        @(posedge clk); #1;
        check({tag, "_endop_low"}, 64'(endop), 64'(0));
        if (!hold) activate = 1'b0;
        k = 0;
        while (k < 40) begin
            if (scramble) begin
                a = 1'($urandom); b = W'($urandom); c = W'($urandom);
            end
            @(posedge clk); #1;
            k++;
            if (endop) break;
        end
        activate = 1'b0;
        check({tag, "_latency"}, 64'(k), 64'(el));
        check({tag, "_div"}, 64'(div), 64'(ed));
        check({tag, "_mod"}, 64'(mod), 64'(em));
    endtask

    initial begin
        int n;
        logic [W-1:0] hd;
        logic hm;

        reset = 1'b0; activate = 1'b0; a = 1'b0; b = '0; c = '0;
        #1;
        check("rst_div", 64'(div), 64'(0));
        check("rst_mod", 64'(mod), 64'(0));
        check("rst_endop", 64'(endop), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        run_op(1'b0, 8'd2, 8'd5, 1'b0, 1'b0, "u_basic");
        run_op(1'b0, 8'd16, 8'd17, 1'b0, 1'b0, "u_ovf1");
        run_op(1'b0, 8'd255, 8'd255, 1'b0, 1'b0, "u_ovf2");
        run_op(1'b1, 8'hFD, 8'd7, 1'b0, 1'b0, "s_neg21");
        run_op(1'b1, 8'h80, 8'hFF, 1'b0, 1'b0, "s_min_m1");
        run_op(1'b1, 8'h80, 8'd1, 1'b0, 1'b0, "s_min_p1");
        run_op(1'b1, 8'hF0, 8'd8, 1'b0, 1'b0, "s_edge_m128");
        run_op(1'b1, 8'h0F, 8'd9, 1'b0, 1'b0, "s_edge_p135");
        run_op(1'b0, 8'd3, 8'd0, 1'b0, 1'b0, "u_c_zero");

        // Start held high and operands scrambled during the operation
        @(negedge clk);
        run_op(1'b0, 8'd13, 8'd11, 1'b1, 1'b1, "hold");
        // Back-to-back start on the edge right after endop
        run_op(1'b1, 8'hF9, 8'hFA, 1'b0, 1'b0, "b2b");

        repeat (2) @(negedge clk);
        run_op(1'b0, 8'd0, 8'd200, 1'b0, 1'b0, "zero");
        hd = div; hm = mod;
        n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (div !== hd || mod !== hm || endop !== 1'b0) n++;
        end
        check("zero_hold", 64'(n), 64'(0));

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            run_op(1'(i % 2), W'($urandom), W'($urandom), 1'b0, 1'b0, $sformatf("rand%0d", i));
        end

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        run_op(1'b0, 8'd9, 8'd9, 1'b0, 1'b0, "pre_rst");
        @(negedge clk);
        a = 1'b0; b = 8'd200; c = 8'd3; activate = 1'b1;
        @(posedge clk); #1 activate = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_div", 64'(div), 64'(0));
        check("mid_rst_mod", 64'(mod), 64'(0));
        check("mid_rst_endop", 64'(endop), 64'(0));
        @(negedge clk) reset = 1'b1;
        n = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (endop) n++;
        end
        check("post_rst_no_endop", 64'(n), 64'(0));
        check("post_rst_div", 64'(div), 64'(0));
        run_op(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, "post_rst_op");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/mult.md
Name: mult

Overview:
- Sequential radix-2 shift-add integer multiplier for the ALU arithmetic group.
- A one-cycle `activate` pulse launches the operation. Operand `b` is the multiplicand, operand `c` is the multiplier, and mode bit `a` selects signed or unsigned.
- Result is the low WIDTH bits of the product on `div`, an overflow flag on `mod`, and a one-cycle completion strobe `endop`.
- The ALU sequencer starts the block and waits for `endop`.

Parameters:
- WIDTH, default 8: operand and result width in bits; legal range 2..32.

Ports:
- clk: input, 1 bit. Single clock; all state updates on its rising edge.
- reset: input, 1 bit. Asynchronous, active-low reset (0 = reset asserted).
- activate: input, 1 bit. Start request, sampled on a rising edge of clk.
- a: input, 1 bit. Mode: 1 = signed two's complement, 0 = unsigned.
- b: input, WIDTH bits. Multiplicand.
- c: input, WIDTH bits. Multiplier.
- div: output, WIDTH bits. Registered low WIDTH bits of the product.
- mod: output, 1 bit. Registered overflow flag.
- endop: output, 1 bit. One-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - div=0, mod=0, endop=0.
  - All internal registers cleared.
  - Reset asserted mid-operation aborts it; no endop is produced.
  - Leaving reset is synchronous to clk.
- States:
  - IDLE: waiting for a start.
  - BUSY: iterating.
- IDLE, rising edge with activate=1:
  - Latch a, b and c.
  - Clear the 2*WIDTH-bit accumulator.
  - Set the step counter to WIDTH.
  - Go to BUSY.
  - In signed mode, latch |b| and |c| plus sign = b[MSB] XOR c[MSB]. |−2^(WIDTH−1)| is represented as an unsigned WIDTH-bit value.
- BUSY, each rising edge:
  - If multiplier LSB=1, add the multiplicand (shifted by the current step) to the accumulator.
  - Shift the multiplier right by one and decrement the counter.
  - activate is ignored while BUSY; operand inputs may change freely.
- Completion (edge on which the counter reaches 0):
  - Conditionally negate the accumulator when sign=1 (signed mode only).
  - div <= low WIDTH bits of the result.
  - In the same edge: endop <= 1, state <= IDLE.
- Latency:
  - Start sampled at edge N gives endop high from edge N+WIDTH to edge N+WIDTH+1. For WIDTH=8 that is 8 cycles.
  - endop is high for exactly one cycle.
- Overflow rules:
  - Unsigned: mod=1 iff the full product > 2^WIDTH−1.
  - Signed: mod=1 iff the full signed product lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- div and mod hold their values until the next completion or reset.
- Back-to-back operation: activate=1 on the edge after endop rose (state already IDLE) starts a new operation. No idle cycle is required beyond that.
- Zero operands follow the normal path: full latency, div=0, mod=0.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined:
  - Completion also occurs on the first BUSY edge whose post-shift multiplier is zero.
  - Example: c=5 completes at edge N+3; c=0 completes at edge N+1.
  - Results and overflow rules are unchanged.
- Undefined: fixed WIDTH-cycle latency in every case.

Decomposition:
- Package mult_pkg holds:
  - typedef mult_state_e {IDLE, BUSY}
  - localparam DEFAULT_WIDTH = 8
  - function for the counter width, $clog2(WIDTH+1)
- Sub-module mult_sign_fix is combinational. It performs conditional two's-complement negation plus overflow detection on the 2*WIDTH accumulator.
- mult_sign_fix is instantiated once at the completion stage. Everything else stays in mult.

Test Plan:
- Reset: reset=0 asynchronously mid-BUSY → div=0, mod=0, endop=0 immediately; no endop after release.
- Unsigned basic: a=0, b=2, c=5, activate pulse at edge N → endop one cycle at edge N+8, div=10, mod=0. With MULT_EARLY_TERM_EN: endop at N+3.
- Unsigned overflow: a=0, b=16, c=17 → div=16 (272 mod 256), mod=1. Also b=255, c=255 → div=1, mod=1.
- Signed: a=1, b=−3 (0xFD), c=7 → div=0xEB (−21), mod=0. Also b=−128, c=−1 → div=0x80, mod=1. Also b=−128, c=1 → div=0x80, mod=0.
- Handshake:
  - activate held high and operands changed during BUSY → no restart, original result delivered.
  - Back-to-back start one edge after endop → second result correct.
- Zero/hold: a=0, b=0, c=200 → div=0, mod=0 after full latency; div/mod stay stable for 5 idle cycles afterwards.
